// File: rtl/valtrain_pattern_detector_if.sv
// Valid-lane training detector bus: enable/word inputs and result/count outputs.
// Latency: none, wires only. Optional error-log signals need VALTRAIN_DET_ERR_LOG_EN.
// Backpressure: none; a word is consumed whenever i_word_valid is high.
interface valtrain_pattern_detector_if #(
    parameter int CNT_W = 6
);
    logic             i_enable;
    logic             i_word_valid;
    logic [31:0]      i_rvld_l;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [CNT_W-1:0] o_match_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [CNT_W-1:0] o_max_run;
`ifdef VALTRAIN_DET_ERR_LOG_EN
    logic [31:0]      o_first_err_word;
    logic [CNT_W-1:0] o_first_err_idx;

    modport master (
        output i_enable, i_word_valid, i_rvld_l,
        input  o_busy, o_done, o_pass, o_match_cnt, o_err_cnt, o_max_run,
        input  o_first_err_word, o_first_err_idx
    );
    modport slave (
        input  i_enable, i_word_valid, i_rvld_l,
        output o_busy, o_done, o_pass, o_match_cnt, o_err_cnt, o_max_run,
        output o_first_err_word, o_first_err_idx
    );
`else
    modport master (
        output i_enable, i_word_valid, i_rvld_l,
        input  o_busy, o_done, o_pass, o_match_cnt, o_err_cnt, o_max_run
    );
    modport slave (
        input  i_enable, i_word_valid, i_rvld_l,
        output o_busy, o_done, o_pass, o_match_cnt, o_err_cnt, o_max_run
    );
`endif
endinterface

// File: rtl/valtrain_pattern_detector.sv
// Checks received valid-lane words against the training pattern; one pass/fail per window.
// Latency: counts and o_done/o_pass are registered, visible the cycle after the word is sampled.
// Backpressure: none; words with i_word_valid=0 are ignored. VALTRAIN_DET_ERR_LOG_EN adds first-error log.
module valtrain_pattern_detector #(
    parameter logic [31:0] PATTERN        = 32'hF0F0F0F0,
    parameter int          WINDOW         = 32,
    parameter int          PASS_THRESHOLD = 16,
    parameter int          CNT_W          = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    valtrain_pattern_detector_if.slave   det_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] THR_C = CNT_W'(PASS_THRESHOLD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] max_run_q, max_run_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] search_cnt_q, search_cnt_d;
    logic [CNT_W-1:0] run_inc;
    logic             word_match;
`ifdef VALTRAIN_DET_ERR_LOG_EN
    logic [31:0]      first_err_word_q, first_err_word_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
`endif

    assign word_match = (det_if.i_rvld_l == PATTERN);
    assign run_inc    = run_q + ONE_C;

    // State and counter registers; async reset returns to IDLE with everything cleared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= IDLE;
            match_cnt_q      <= '0;
            err_cnt_q        <= '0;
            max_run_q        <= '0;
            run_q            <= '0;
            idx_q            <= '0;
            search_cnt_q     <= '0;
`ifdef VALTRAIN_DET_ERR_LOG_EN
            first_err_word_q <= '0;
            first_err_idx_q  <= '0;
`endif
        end else begin
            state_q          <= state_d;
            match_cnt_q      <= match_cnt_d;
            err_cnt_q        <= err_cnt_d;
            max_run_q        <= max_run_d;
            run_q            <= run_d;
            idx_q            <= idx_d;
            search_cnt_q     <= search_cnt_d;
`ifdef VALTRAIN_DET_ERR_LOG_EN
            first_err_word_q <= first_err_word_d;
            first_err_idx_q  <= first_err_idx_d;
`endif
        end
    end

    // Next-state and counter updates; dropping i_enable overrides everything and clears.
    always_comb begin
        state_d          = state_q;
        match_cnt_d      = match_cnt_q;
        err_cnt_d        = err_cnt_q;
        max_run_d        = max_run_q;
        run_d            = run_q;
        idx_d            = idx_q;
        search_cnt_d     = search_cnt_q;
`ifdef VALTRAIN_DET_ERR_LOG_EN
        first_err_word_d = first_err_word_q;
        first_err_idx_d  = first_err_idx_q;
`endif
        case (state_q)
            IDLE: begin
                // The enabling cycle's word is deliberately not evaluated.
                if (det_if.i_enable) state_d = SEARCH;
            end
            SEARCH: begin
                if (det_if.i_word_valid) begin
                    if (word_match) begin
                        // Lock word counts as word 1 of the window.
                        state_d     = CHECK;
                        match_cnt_d = ONE_C;
                        run_d       = ONE_C;
                        max_run_d   = ONE_C;
                        idx_d       = ONE_C;
                    end else if (search_cnt_q == WIN_C - ONE_C) begin
                        // Never locked within a full window: report a full-window failure.
                        state_d      = DONE;
                        search_cnt_d = WIN_C;
                        err_cnt_d    = WIN_C;
                    end else begin
                        search_cnt_d = search_cnt_q + ONE_C;
                    end
                end
            end
            CHECK: begin
                if (det_if.i_word_valid) begin
                    idx_d = idx_q + ONE_C;
                    if (word_match) begin
                        match_cnt_d = match_cnt_q + ONE_C;
                        run_d       = run_inc;
                        if (run_inc > max_run_q) max_run_d = run_inc;
                    end else begin
                        err_cnt_d = err_cnt_q + ONE_C;
                        run_d     = '0;
`ifdef VALTRAIN_DET_ERR_LOG_EN
                        // Index is 1-based, so zero doubles as "nothing logged yet".
                        if (first_err_idx_q == '0) begin
                            first_err_word_d = det_if.i_rvld_l;
                            first_err_idx_d  = idx_q + ONE_C;
                        end
`endif
                    end
                    if (idx_q + ONE_C == WIN_C) state_d = DONE;
                end
            end
            default: begin
                // DONE: counts frozen until enable drops.
            end
        endcase
        if (!det_if.i_enable) begin
            state_d          = IDLE;
            match_cnt_d      = '0;
            err_cnt_d        = '0;
            max_run_d        = '0;
            run_d            = '0;
            idx_d            = '0;
            search_cnt_d     = '0;
`ifdef VALTRAIN_DET_ERR_LOG_EN
            first_err_word_d = '0;
            first_err_idx_d  = '0;
`endif
        end
    end

    assign det_if.o_busy      = (state_q == SEARCH) || (state_q == CHECK);
    assign det_if.o_done      = (state_q == DONE);
    assign det_if.o_pass      = (state_q == DONE) && (max_run_q >= THR_C);
    assign det_if.o_match_cnt = match_cnt_q;
    assign det_if.o_err_cnt   = err_cnt_q;
    assign det_if.o_max_run   = max_run_q;
`ifdef VALTRAIN_DET_ERR_LOG_EN
    assign det_if.o_first_err_word = first_err_word_q;
    assign det_if.o_first_err_idx  = first_err_idx_q;
`endif

endmodule
